mips_instruction_fetch: RTL and testbench

//  Fetch-side initiator for the 16-bit mini MIPS instruction memory (combinational,

---
 rtl/mips_instruction_fetch_if.sv | 22 ++
 rtl/mips_instruction_fetch.sv | 115 +++++++++++
 tb/tb_mips_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instruction_fetch_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handshake and redirect.
// The master side is the fetch unit; the slave side is the memory/decode/branch environment.
interface mips_instruction_fetch_if;
  logic [31:0] read_address;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output read_address, instr_valid, instr_data, instr_pc,
    input  instruction, instr_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  read_address, instr_valid, instr_data, instr_pc,
    output instruction, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/mips_instruction_fetch.sv
// Instruction fetch for the 16-bit mini MIPS: PC, 2-entry fetch buffer, halt/redirect.
// Optional macro FETCH_BOUNDS_CHECK_EN: faults when the PC leaves the instruction memory.
module mips_instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          MEM_DEPTH = 256
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  mips_instruction_fetch_if.master      bus,
  output logic                          halted,
  output logic                          fault
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc;
  logic [1:0]         count;
  logic [1:0][15:0]   ent_data;
  logic [1:0][31:0]   ent_pc;
  logic               pop, push, oob;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);
  assign oob = (state == RUN) && (pc > LAST_PC);
`else
  assign oob = 1'b0;
`endif

  // A full buffer can still take a word on the edge that drains its head.
  assign pop  = (count != 2'd0) && bus.instr_ready;
  assign push = (state == RUN) && !bus.redirect_valid && !oob &&
                ((count != 2'd2) || pop);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (oob) state_nxt = FAULT;
                 else if (push && (bus.instruction == HALT_WORD)) state_nxt = HALT;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    halted           = (state == HALT);
`ifdef FETCH_BOUNDS_CHECK_EN
    fault            = (state == FAULT);
`else
    fault            = 1'b0;
`endif
    bus.read_address = pc;
    bus.instr_valid  = (count != 2'd0);
    bus.instr_data   = ent_data[0];
    bus.instr_pc     = ent_pc[0];
  end

  // Slot 0 is the head; it keeps its contents when the buffer empties.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      count    <= 2'd0;
      ent_data <= '0;
      ent_pc   <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_target;
      count <= 2'd0;
    end else begin
      if (push) pc <= pc + 32'd1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            ent_data[0] <= bus.instruction;
            ent_pc[0]   <= pc;
          end else begin
            ent_data[1] <= bus.instruction;
            ent_pc[1]   <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            ent_data[0] <= ent_data[1];
            ent_pc[0]   <= ent_pc[1];
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            ent_data[0] <= ent_data[1];
            ent_pc[0]   <= ent_pc[1];
            ent_data[1] <= bus.instruction;
            ent_pc[1]   <= pc;
          end else begin
            ent_data[0] <= bus.instruction;
            ent_pc[0]   <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instruction_fetch.sv
// Bench for mips_instruction_fetch: queue-based fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mips_instruction_fetch;
  localparam int DEPTH = 64;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic start;
  logic halted, fault;
  mips_instruction_fetch_if bus();

  logic [15:0] mem [0:255];
  assign bus.instruction = mem[bus.read_address[7:0]];

  mips_instruction_fetch #(.RESET_PC(32'd0), .HALT_WORD(16'hFFFF), .MEM_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .halted  (halted),
    .fault   (fault)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of {word, pc} plus PC and run state.
  typedef struct { logic [15:0] d; logic [31:0] p; } ent_t;
  ent_t        q[$];
  int          m_state = S_IDLE;
  logic [31:0] m_pc = 32'd0;
  logic [15:0] m_last_d = 16'd0;
  logic [31:0] m_last_p = 32'd0;

  task automatic model_step();
    logic [15:0] w;
    bit          room;
    if (!reset_n) begin
      q.delete();
      m_state = S_IDLE; m_pc = 32'd0; m_last_d = 16'd0; m_last_p = 32'd0;
    end else if (bus.redirect_valid) begin
      q.delete();
      m_pc = bus.redirect_target;
      m_state = S_RUN;
    end else begin
      room = (q.size() < 2) || bus.instr_ready;
      if (q.size() > 0 && bus.instr_ready) void'(q.pop_front());
      if (m_state == S_IDLE && start) m_state = S_RUN;
      else if (m_state == S_RUN) begin
        if (BOUNDS && m_pc > 32'(DEPTH - 1)) m_state = S_FAULT;
        else if (room) begin
          w = mem[m_pc[7:0]];
          q.push_back('{w, m_pc});
          if (w == 16'hFFFF) m_state = S_HALT;
          m_pc = m_pc + 32'd1;
        end
      end
    end
    if (q.size() > 0) begin
      m_last_d = q[0].d;
      m_last_p = q[0].p;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      chk("m_read_address", bus.read_address, m_pc);
      chk("m_instr_valid", 32'(bus.instr_valid), 32'(q.size() > 0));
      chk("m_instr_data", 32'(bus.instr_data), 32'(m_last_d));
      chk("m_instr_pc", bus.instr_pc, m_last_p);
      chk("m_halted", 32'(halted), 32'(m_state == S_HALT));
      chk("m_fault", 32'(fault), 32'(m_state == S_FAULT));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr", bus.read_address, 32'd0);
    chk("rst_data", 32'(bus.instr_data), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Streaming with ready=1, stray start while running
    bus.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_addr_n1", bus.read_address, 32'd0);
    chk("a_valid_n1", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("a_data0", 32'(bus.instr_data), 32'h1111);
    chk("a_pc0", bus.instr_pc, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_data1", 32'(bus.instr_data), 32'h2222);
    chk("a_pc1", bus.instr_pc, 32'd1);
    tick();
    chk("a_data2", 32'(bus.instr_data), 32'h3333);
    tick();
    chk("a_data3", 32'(bus.instr_data), 32'h4444);
    chk("a_pc3", bus.instr_pc, 32'd3);

    // Stall: buffer fills, PC holds at 2
    bus.instr_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("b_addr_hold", bus.read_address, 32'd2);
    chk("b_valid", 32'(bus.instr_valid), 32'd1);
    chk("b_data_hold", 32'(bus.instr_data), 32'h1111);
    bus.instr_ready = 1'b1;
    tick();
    chk("b_data1", 32'(bus.instr_data), 32'h2222);
    chk("b_pc1", bus.instr_pc, 32'd1);
    tick();
    chk("b_data2", 32'(bus.instr_data), 32'h3333);
    chk("b_pc2", bus.instr_pc, 32'd2);

    // Redirect with two entries buffered
    bus.instr_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h20;
    tick();
    bus.redirect_valid = 1'b0;
    chk("c_valid_flush", 32'(bus.instr_valid), 32'd0);
    chk("c_addr", bus.read_address, 32'h20);
    tick();
    chk("c_valid", 32'(bus.instr_valid), 32'd1);
    chk("c_pc20", bus.instr_pc, 32'h20);
    chk("c_data20", 32'(bus.instr_data), 32'h1020);
    bus.instr_ready = 1'b1;
    tick();
    chk("c_pc21", bus.instr_pc, 32'h21);

    // Halt word, then redirect out of HALT
    do_reset();
    mem[2] = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("d_data_halt", 32'(bus.instr_data), 32'hFFFF);
    chk("d_pc_halt", bus.instr_pc, 32'd2);
    chk("d_halted", 32'(halted), 32'd1);
    chk("d_addr", bus.read_address, 32'd3);
    tick();
    chk("d_valid_drained", 32'(bus.instr_valid), 32'd0);
    chk("d_addr_hold", bus.read_address, 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("d_unhalted", 32'(halted), 32'd0);
    chk("d_addr0", bus.read_address, 32'd0);
    tick();
    mem[2] = 16'h3333;
    chk("d_refetch", 32'(bus.instr_data), 32'h1111);

    // Reset mid-stream with a valid buffer
    bus.instr_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("e_valid_pre", 32'(bus.instr_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("e_valid", 32'(bus.instr_valid), 32'd0);
    chk("e_addr", bus.read_address, 32'd0);
    chk("e_data", 32'(bus.instr_data), 32'd0);
    chk("e_pc", bus.instr_pc, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("e_idle_addr", bus.read_address, 32'd0);

    // Memory bound: pcs DEPTH-4..DEPTH-1, then fault or run-on
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'(DEPTH - 4);
    tick();
    bus.redirect_valid = 1'b0;
    chk("f_addr", bus.read_address, 32'(DEPTH - 4));
    repeat (4) tick();
    chk("f_last_pc", bus.instr_pc, 32'(DEPTH - 1));
    tick();
    if (BOUNDS) begin
      chk("f_fault", 32'(fault), 32'd1);
      chk("f_valid", 32'(bus.instr_valid), 32'd0);
      chk("f_addr_hold", bus.read_address, 32'(DEPTH));
    end else begin
      chk("f_nofault", 32'(fault), 32'd0);
      chk("f_pc_past", bus.instr_pc, 32'(DEPTH));
      chk("f_addr_past", bus.read_address, 32'(DEPTH + 1));
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("f_fault_clear", 32'(fault), 32'd0);
    chk("f_addr0", bus.read_address, 32'd0);
    bus.instr_ready = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
